// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Holds the register-file geometry, the hard-wired zero register index,
// and the write-back entry type used by the write queue and the
// write-back stage.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Register 0 is hard-wired to zero; writes to it are dropped.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_queue_lookup.sv
// wq_lookup: combinational youngest-match search over the write queue.
// Ports:
//   addr   - lookup register index (index 0 never hits)
//   head   - queue head pointer; age order runs from head towards tail
//   addrs  - per-slot register index
//   datas  - per-slot write data
//   valid  - per-slot valid mask
//   hit    - some valid slot holds addr
//   data   - value of the youngest matching slot, 0 on miss
module wq_lookup #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [PTR_W-1:0]              head,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  addrs,
  input  logic [DEPTH-1:0][DATA_W-1:0]  datas,
  input  logic [DEPTH-1:0]              valid,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);
  import regfile_pkg::REG_ZERO;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overwrites an earlier one,
  // so the entry nearest the tail wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (addrs[idx] == addr) && (addr != REG_ZERO)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back buffer in front of the
// register-file write port, with two forwarding lookups.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_valid/in_ready   - write-back request handshake
//   in_addr, in_data    - request register index and value
//   wr_stall            - register-file write port busy this cycle
//   wr_en/addr/data     - register-file write port (RegWrite etc.)
//   lk_addr1/2          - forwarding lookup indices
//   lk_hit1/2, data1/2  - forwarding results (youngest queued match)
//   count, empty        - occupancy
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lk_addr1,
  input  logic [ADDR_W-1:0] lk_addr2,
  output logic              lk_hit1,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data1,
  output logic [DATA_W-1:0] lk_data2,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  import regfile_pkg::wb_entry_t;
  import regfile_pkg::REG_ZERO;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_entry_t [DEPTH-1:0]        mem_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [CNT_W-1:0]             count_q;

  logic                         push;
  logic                         pop;
  wb_entry_t                    head_entry;
  logic [DEPTH-1:0][ADDR_W-1:0] slot_addrs;
  logic [DEPTH-1:0][DATA_W-1:0] slot_datas;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < FULL);

  // Writes to register 0 complete the handshake but never occupy a slot.
  assign push = in_valid && in_ready && (in_addr != REG_ZERO);
  assign pop  = !empty && !wr_stall;

  assign head_entry = mem_q[head_q];
  assign wr_en   = pop;
  assign wr_addr = empty ? '0 : head_entry.addr;
  assign wr_data = empty ? '0 : head_entry.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Push and pop never target the same slot: a push needs count < DEPTH
      // and a pop needs count > 0, so tail != head whenever both fire.
      if (push) begin
        mem_q[tail_q]   <= '{addr: in_addr, data: in_data};
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    slot_addrs = '0;
    slot_datas = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_addrs[i] = mem_q[i].addr;
      slot_datas[i] = mem_q[i].data;
    end
  end

  wq_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_lookup1 (
    .addr (lk_addr1),
    .head (head_q),
    .addrs(slot_addrs),
    .datas(slot_datas),
    .valid(valid_q),
    .hit  (lk_hit1),
    .data (lk_data1)
  );

  wq_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_lookup2 (
    .addr (lk_addr2),
    .head (head_q),
    .addrs(slot_addrs),
    .datas(slot_datas),
    .valid(valid_q),
    .hit  (lk_hit2),
    .data (lk_data2)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;
  import regfile_pkg::wb_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wr_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  lk_addr1, lk_addr2;
  logic        lk_hit1, lk_hit2;
  logic [31:0] lk_data1, lk_data2;
  logic [2:0]  count;
  logic        empty;

  int pass_cnt   = 0;
  int total_cnt  = 0;
  int commit_cnt = 0;
  int saved_commits;
  wb_entry_t sb[$];

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Every commit must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      chk("commit_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wb_entry_t e;
        e = sb.pop_front();
        chk("commit_addr", 64'(wr_addr), 64'(e.addr));
        chk("commit_data", 64'(wr_data), 64'(e.data));
      end
      commit_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] a, input logic [31:0] d, input logic exp_accept);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    chk("push_ready", 64'(in_ready), 64'(exp_accept));
    if (exp_accept && a != 5'd0) sb.push_back('{addr: a, data: d});
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wr_stall = 1'b0; lk_addr1 = 5'd3; lk_addr2 = 5'd4;

    // reset values
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_lk_hit1", 64'(lk_hit1), 64'd0);
    chk("rst_lk_data1", 64'(lk_data1), 64'd0);
    cycle();
    rst = 1'b0;

    // single push, two-edge latency
    push_one(5'd3, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t1_wr_en", 64'(wr_en), 64'd1);
    chk("t1_wr_addr", 64'(wr_addr), 64'd3);
    chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("t1_lk_hit1", 64'(lk_hit1), 64'd1);
    chk("t1_lk_data1", 64'(lk_data1), 64'hDEADBEEF);
    cycle();
    chk("t1_empty", 64'(empty), 64'd1);

    // fill under stall, 5th rejected, then drain in order
    wr_stall = 1'b1;
    for (int k = 1; k <= 4; k++) push_one(5'(k), 32'(k * 'h11), 1'b1);
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h77;
    @(negedge clk);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_ready_full", 64'(in_ready), 64'd0);
    chk("t2_wr_en_stalled", 64'(wr_en), 64'd0);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count_still_full", 64'(count), 64'd4);
    cycle();
    wr_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_drain_wr_en", 64'(wr_en), 64'd1);
      chk("t2_drain_addr", 64'(wr_addr), 64'(k));
      cycle();
    end
    chk("t2_empty", 64'(empty), 64'd1);

    // register 0 write is dropped
    saved_commits = commit_cnt;
    push_one(5'd0, 32'hFFFFFFFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_count", 64'(count), 64'd0);
      chk("t3_wr_en", 64'(wr_en), 64'd0);
      cycle();
    end
    chk("t3_no_commit", 64'(commit_cnt), 64'(saved_commits));

    // forwarding: youngest match wins, miss returns 0
    wr_stall = 1'b1;
    lk_addr1 = 5'd5; lk_addr2 = 5'd6;
    push_one(5'd5, 32'hA, 1'b1);
    @(negedge clk);
    chk("t4_lk_data1_one", 64'(lk_data1), 64'hA);
    cycle();
    push_one(5'd5, 32'hB, 1'b1);
    @(negedge clk);
    chk("t4_lk_hit1", 64'(lk_hit1), 64'd1);
    chk("t4_lk_data1", 64'(lk_data1), 64'hB);
    chk("t4_lk_hit2", 64'(lk_hit2), 64'd0);
    chk("t4_lk_data2", 64'(lk_data2), 64'd0);
    lk_addr2 = 5'd0;
    #1;
    chk("t4_lk_zero_hit", 64'(lk_hit2), 64'd0);
    cycle();
    wr_stall = 1'b0;
    cycle(); cycle();
    chk("t4_empty", 64'(empty), 64'd1);

    // sustained push+pop at count 2 across pointer wrap
    wr_stall = 1'b1;
    push_one(5'd10, 32'h1010, 1'b1);
    push_one(5'd11, 32'h1111, 1'b1);
    wr_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = 5'(12 + i);
      in_data  = $urandom;
      @(negedge clk);
      chk("t5_count", 64'(count), 64'd2);
      chk("t5_ready", 64'(in_ready), 64'd1);
      sb.push_back('{addr: in_addr, data: in_data});
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_sb_drained", 64'(sb.size()), 64'd0);

    // async reset with entries queued
    wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) push_one(5'(20 + k), 32'(k + 'h500), 1'b1);
    chk("t6_count_pre", 64'(count), 64'd3);
    wr_stall = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_wr_en_rst", 64'(wr_en), 64'd0);
    chk("t6_count_rst", 64'(count), 64'd0);
    chk("t6_lk_hit1_rst", 64'(lk_hit1), 64'd0);
    sb.delete();
    saved_commits = commit_cnt;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    chk("t6_no_commit", 64'(commit_cnt), 64'(saved_commits));
    chk("t6_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side front end for the 32×32 register file: accepts register write-back requests from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file's write port (RegWrite/WriteRegister/WriteData), honouring a stall input. It also provides two combinational forwarding lookups, so read-side consumers see data still queued and not yet committed to the register file.

## Interface
- DEPTH, 4, number of queued entries (power of two, ≥2)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer offers a write-back request
- in_ready  output  1  queue can accept; high iff count < DEPTH
- in_addr  input  ADDR_W  destination register index
- in_data  input  DATA_W  write-back value
- wr_stall  input  1  register-file write port unavailable this cycle
- wr_en  output  1  drives RegWrite
- wr_addr  output  ADDR_W  drives WriteRegister
- wr_data  output  DATA_W  drives WriteData
- lk_addr1, lk_addr2  input  ADDR_W  forwarding lookup indices (mirror ReadRegister1/2)
- lk_hit1, lk_hit2  output  1  lookup matched a queued entry
- lk_data1, lk_data2  output  DATA_W  youngest matching queued value; 0 on miss
- count  output  $clog2(DEPTH)+1  number of valid entries
- empty  output  1  count == 0

## Operation
- Push: in_valid && in_ready at a rising edge. If in_addr == 0, the request is accepted and discarded (no entry, count unchanged). Otherwise {in_addr, in_data} is written at the tail, and the tail pointer advances modulo DEPTH.
- Pop: wr_en = !empty && !wr_stall. wr_addr/wr_data show the head entry whenever !empty, and are 0 when empty. When wr_en is high, the head is retired at the edge (the register file captures it on the same edge).
- Simultaneous push and pop: both occur and count is unchanged. in_ready depends only on registered count; it does not look ahead to a same-cycle pop. At count == DEPTH, in_ready = 0 even if wr_en = 1.
- Ordering: strict FIFO, so multiple writes to the same register commit oldest-first.
- Lookup: compares lk_addrN against all valid entries, including the head being written this cycle. On multiple matches, the youngest (closest to tail) wins. lk_addrN == 0 never hits. The same-cycle in_data is not forwarded.
- Overflow and underflow are impossible by construction. A pop when empty is a no-op.

## Timing
- Reset values: count 0, empty 1, in_ready 1, wr_en 0, wr_addr 0, wr_data 0, lk_hit* 0, lk_data* 0. Pointers are 0 and entries are invalidated.
- Latency: an accepted entry appears on wr_* in the cycle after the push edge. If it is the only entry and there is no stall, it commits at the next edge, for 2 edges in-to-regfile.
- Throughput: 1 push and 1 pop per cycle sustained.
- wr_en, wr_*, lk_*, and empty are combinational from registered state plus wr_stall and lk_addr*. No input-to-output path exists from in_*.
- Pointer wrap: the tail/head advance from DEPTH-1 to 0. Full and empty are distinguished by count.
- rst asserted mid-operation discards all queued entries immediately, and wr_en drops the same cycle (asynchronously). Discarded entries are never written.

## Structure
- Shared package regfile_pkg: ADDR_W, DATA_W, REG_ZERO index constant, and a typedef wb_entry_t {addr, data}, also reused by the write-back stage.
- One sub-module, wq_lookup: a purely combinational youngest-match priority search over the entry array and valid mask. It is instantiated twice, once per lookup port.
- The top level holds the entry array, valid bits, head/tail pointers, and count.

## Test plan
- Reset, then push {3, 0xDEADBEEF} with no stall: wr_en = 1, wr_addr = 3, wr_data = 0xDEADBEEF in the next cycle, and empty = 1 after that edge.
- wr_stall held high, push 4 entries (regs 1–4, data 0x11–0x44): count = 4, in_ready = 0, and a 5th in_valid is not accepted. Release the stall: regs 1, 2, 3, 4 commit on 4 consecutive edges.
- Push to register 0 with data 0xFFFFFFFF: count stays 0 and wr_en is never asserted.
- With the stall, queue {5, 0xA}, then {5, 0xB}, with lk_addr1 = 5: lk_hit1 = 1 and lk_data1 = 0xB. With lk_addr2 = 6: lk_hit2 = 0 and lk_data2 = 0.
- With count = 2 and no stall, push each cycle for 10 cycles: count stays at 2, pointers wrap, and commit order matches push order.
- Assert rst with 3 entries queued: wr_en = 0 immediately, count = 0, and no further writes after release.
